core_mem_bus: RTL and testbench

//  Memory/MMIO slave sitting directly downstream of the multicycle core. It consumes address/data_out/we
//  and returns data_in with one-cycle registered read latency. It holds a word-addressed unified

---
 rtl/core_mem_bus.sv | 172 +++++++++++++++++
 tb/tb_core_mem_bus.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_bus.sv
// rtl/core_mem_bus.sv - unified RAM plus MMIO page (exit latch, TX byte FIFO, status, cycle counter)
// One bus port from the core with registered read data; all MMIO state lives in this file.
module core_mem_bus #(
    parameter int          MEM_WORDS  = 512,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h800
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    input  logic        we,
    output logic [31:0] data_in,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [29:0]      RAM_WORDS = 30'(MEM_WORDS);
    localparam logic [29:0]      MMIO_WORD = MMIO_BASE[31:2];

    // Decode
    logic [29:0]      word_a;
    logic [IDX_W-1:0] ram_idx;
    logic             sel_ram;
    logic             sel_exit;
    logic             sel_txdata;
    logic             sel_txstat;
    logic             sel_cycle;
    logic             unused_addr_bits;

    assign word_a           = address[31:2];
    assign ram_idx          = address[IDX_W+1:2];
    assign unused_addr_bits = ^address[1:0];

    always_comb begin
        sel_ram    = (word_a < RAM_WORDS);
        sel_exit   = !sel_ram && (word_a == MMIO_WORD);
        sel_txdata = !sel_ram && (word_a == MMIO_WORD + 30'd1);
        sel_txstat = !sel_ram && (word_a == MMIO_WORD + 30'd2);
        sel_cycle  = !sel_ram && (word_a == MMIO_WORD + 30'd3);
    end

    // RAM has no reset so it survives a core reset with its program intact
    logic [31:0] ram_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we && sel_ram) begin
            ram_q[ram_idx] <= data_out;
        end
    end

    // Registered state
    logic [31:0]      data_in_q,   data_in_d;
    logic             halt_q,      halt_d;
    logic [31:0]      halt_code_q, halt_code_d;
    logic             ovf_q,       ovf_d;
    logic [31:0]      cycle_q,     cycle_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       fifo_d [FIFO_DEPTH];

    logic full;
    logic empty;
    logic pop;
    logic push_req;
    logic push_ok;

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        pop      = !empty && tx_ready;
        push_req = we && sel_txdata;
        // A full FIFO still accepts a push when the head leaves on the same edge
        push_ok  = push_req && (!full || pop);
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = data_out[7:0];
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d       = ovf_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        cycle_d     = cycle_q + 32'd1;
        if (we && sel_txstat) begin
            ovf_d = 1'b0;
        end
        // Set after clear so a dropped byte is never lost from the status
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (we && sel_exit) begin
            halt_d      = 1'b1;
            halt_code_d = data_out;
        end
    end

    // Read mux samples pre-edge state, giving read-before-write everywhere
    always_comb begin
        data_in_d = '0;
        if (sel_ram) begin
            data_in_d = ram_q[ram_idx];
        end else if (sel_exit) begin
            data_in_d = halt_code_q;
        end else if (sel_txstat) begin
            data_in_d = {29'b0, ovf_q, empty, full};
        end else if (sel_cycle) begin
            data_in_d = cycle_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_in_q   <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            ovf_q       <= 1'b0;
            cycle_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            data_in_q   <= data_in_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            ovf_q       <= ovf_d;
            cycle_q     <= cycle_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_q      <= fifo_d;
        end
    end

    assign data_in   = data_in_q;
    assign tx_valid  = !empty;
    assign tx_data   = fifo_q[rd_ptr_q];
    assign halt      = halt_q;
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_core_mem_bus.sv
// tb/tb_core_mem_bus.sv - table vectors, directed FIFO/cycle/reset sequences and random traffic vs a queue model
module tb_core_mem_bus;

    localparam int MEM_WORDS = 512;
    localparam int DEPTH     = 4;
    localparam logic [31:0] IDLE = 32'h0000_0900;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] address;
    logic [31:0] data_out;
    logic        we;
    logic [31:0] data_in;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic [31:0] halt_code;

    always #5 clk = ~clk;

    core_mem_bus #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(DEPTH), .MMIO_BASE(32'h800)) dut (
        .clk(clk), .resetn(resetn), .address(address), .data_out(data_out), .we(we),
        .data_in(data_in), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .halt(halt), .halt_code(halt_code)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [MEM_WORDS];
    bit          known_m [MEM_WORDS];
    logic [7:0]  q_m [$];
    bit          ovf_m;
    bit          halt_m;
    logic [31:0] code_m;
    logic [31:0] cyc_m;
    logic [31:0] last_rd;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        w;
        logic [31:0] exp_rd;
        logic        exp_halt;
    } vec_t;
    vec_t tbl [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        ovf_m  = 1'b0;
        halt_m = 1'b0;
        code_m = '0;
        cyc_m  = '0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                              output logic [31:0] er, output bit kn);
        logic [31:0] wa;
        int idx;
        bit is_ram;
        idx    = 0;
        kn     = 1'b1;
        er     = '0;
        wa     = a & ~32'h3;
        is_ram = (a < 32'(4 * MEM_WORDS));
        if (is_ram) begin
            idx = int'(a >> 2);
            er  = mem_m[idx];
            kn  = known_m[idx];
        end else if (wa == 32'h800) er = code_m;
        else if (wa == 32'h808) er = {29'b0, ovf_m, q_m.size() == 0, q_m.size() == DEPTH};
        else if (wa == 32'h80C) er = cyc_m;
        if (r && q_m.size() > 0) void'(q_m.pop_front());
        if (w) begin
            if (is_ram) begin
                mem_m[idx]   = d;
                known_m[idx] = 1'b1;
            end else if (wa == 32'h800) begin
                halt_m = 1'b1;
                code_m = d;
            end else if (wa == 32'h804) begin
                if (q_m.size() < DEPTH) q_m.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end else if (wa == 32'h808) begin
                ovf_m = 1'b0;
            end
        end
        cyc_m = cyc_m + 32'd1;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        logic [31:0] er;
        bit kn;
        address  = a;
        data_out = d;
        we       = w;
        tx_ready = r;
        model_edge(a, d, w, r, er, kn);
        @(posedge clk);
        #1;
        last_rd = data_in;
        if (kn) check("rd_data", data_in, er);
        check("tx_valid", {31'b0, tx_valid}, {31'b0, q_m.size() != 0});
        if (q_m.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, q_m[0]});
        check("halt", {31'b0, halt}, {31'b0, halt_m});
        check("halt_code", halt_code, code_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;

        tbl[0]  = '{32'h004, 32'h0,        1'b0, 32'hC0DE0001, 1'b0};
        tbl[1]  = '{32'h006, 32'h0,        1'b0, 32'hC0DE0001, 1'b0};
        tbl[2]  = '{32'h010, 32'h12345678, 1'b1, 32'hC0DE0004, 1'b0};
        tbl[3]  = '{32'h010, 32'h0,        1'b0, 32'h12345678, 1'b0};
        tbl[4]  = '{32'h800, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b1};
        tbl[5]  = '{32'h803, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        tbl[6]  = '{32'h800, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        tbl[7]  = '{32'h804, 32'h0,        1'b0, 32'h00000000, 1'b1};
        tbl[8]  = '{32'h808, 32'h0,        1'b0, 32'h00000002, 1'b1};
        tbl[9]  = '{32'h7FC, 32'h0,        1'b0, 32'hC0DE01FF, 1'b1};
        tbl[10] = '{32'h810, 32'h0,        1'b0, 32'h00000000, 1'b1};
        tbl[11] = '{32'h800, 32'h0000CAFE, 1'b1, 32'hDEADBEEF, 1'b1};
        tbl[12] = '{32'h900, 32'h00000001, 1'b1, 32'h00000000, 1'b1};
        tbl[13] = '{32'h000, 32'h0,        1'b0, 32'hC0DE0000, 1'b1};

        resetn = 1'b0; address = '0; data_out = '0; we = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) known_m[i] = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_in", data_in, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_halt_code", halt_code, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++) step(32'(4 * i), 32'hC0DE0000 | 32'(i), 1'b1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].addr, tbl[i].wd, tbl[i].w, 1'b0);
            check($sformatf("tbl%0d_rd", i), data_in, tbl[i].exp_rd);
            check($sformatf("tbl%0d_halt", i), {31'b0, halt}, {31'b0, tbl[i].exp_halt});
        end

        for (int i = 0; i < 5; i++) step(32'h804, 32'h41 + 32'(i), 1'b1, 1'b0);
        step(32'h808, 32'h0, 1'b0, 1'b0);
        check("ovf_status", last_rd, 32'h5);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", {24'b0, tx_data}, 32'h41 + 32'(i));
            step(IDLE, 32'h0, 1'b0, 1'b1);
        end
        check("drain_empty", {31'b0, tx_valid}, 32'h0);
        step(32'h808, 32'h0, 1'b0, 1'b1);
        check("empty_status", last_rd, 32'h6);
        step(32'h808, 32'h0, 1'b1, 1'b0);
        step(32'h808, 32'h0, 1'b0, 1'b0);
        check("ovf_cleared", last_rd, 32'h2);

        for (int i = 0; i < 4; i++) step(32'h804, 32'h51 + 32'(i), 1'b1, 1'b0);
        check("full_head", {24'b0, tx_data}, 32'h51);
        step(32'h804, 32'h55, 1'b1, 1'b1);
        check("pushpop_head", {24'b0, tx_data}, 32'h52);
        step(32'h808, 32'h0, 1'b0, 1'b0);
        check("pushpop_status", last_rd, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("pushpop_order", {24'b0, tx_data}, 32'h52 + 32'(i));
            step(IDLE, 32'h0, 1'b0, 1'b1);
        end
        check("pushpop_empty", {31'b0, tx_valid}, 32'h0);

        step(32'h804, 32'h60, 1'b1, 1'b0);
        check("one_head", {24'b0, tx_data}, 32'h60);
        step(32'h804, 32'h61, 1'b1, 1'b1);
        check("one_valid", {31'b0, tx_valid}, 32'h1);
        check("one_newhead", {24'b0, tx_data}, 32'h61);
        step(IDLE, 32'h0, 1'b0, 1'b1);

        step(32'h80C, 32'h0, 1'b0, 1'b0);
        c1 = last_rd;
        repeat (6) step(IDLE, 32'h0, 1'b0, 1'b0);
        step(32'h80C, 32'hFFFFFFFF, 1'b1, 1'b0);
        c2 = last_rd;
        check("cycle_delta", c2 - c1, 32'd7);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            int unsigned k;
            k = $urandom_range(0, 10);
            case (k)
                0, 1, 2, 3: a = 32'(4 * $urandom_range(0, 15));
                4:          a = 32'(4 * $urandom_range(0, MEM_WORDS - 1));
                5:          a = 32'h800;
                6, 7:       a = 32'h804;
                8:          a = 32'h808;
                9:          a = 32'h80C;
                default:    a = 32'h810 + ($urandom & 32'h00FF_FFF0);
            endcase
            a = a | 32'($urandom_range(0, 3));
            step(a, $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        step(32'h804, 32'h77, 1'b1, 1'b0);
        step(32'h804, 32'h78, 1'b1, 1'b0);
        check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
        address = 32'h804; data_out = 32'h79; we = 1'b1;
        #3 resetn = 1'b0;
        #1;
        check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_tx_data", {24'b0, tx_data}, 32'h0);
        check("async_data_in", data_in, 32'h0);
        check("async_halt", {31'b0, halt}, 32'h0);
        check("async_halt_code", halt_code, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
        step(32'h80C, 32'h0, 1'b0, 1'b0);
        check("cycle_after_rst", last_rd, 32'h0);
        step(32'h80C, 32'h0, 1'b0, 1'b0);
        check("cycle_after_rst1", last_rd, 32'h1);
        step(32'h7FC, 32'h0, 1'b0, 1'b0);
        check("ram_kept", last_rd, mem_m[MEM_WORDS - 1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
